// File: rtl/value_glyph_encoder.sv
// value_glyph_encoder
//   Converts an unsigned binary value into DIGITS decimal glyph codes for the 7x9
//   glyph renderers of the on-screen readout. The conversion is a sequential
//   shift-add-3 (double-dabble) that takes one VALUE_W-bit shift per clock. The
//   result is committed to the outputs only on frame_start, so a readout never
//   changes in the middle of a frame.
//   Glyph codes: 0..9 are digits, 16 is blank, 17 is '-'.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   start        conversion request, accepted only while ready=1
//   value        unsigned binary input, sampled on the accepting edge
//   frame_start  one-cycle pulse at the start of each video frame (commit strobe)
//   ready        high only while idle
//   glyphs       5 bits per digit; [4:0] is the units digit, the top field is the MSD
//   done         one-cycle pulse in the cycle after a commit
//   overflow     the last committed value exceeded 10^DIGITS-1
module value_glyph_encoder #(
  parameter int DIGITS   = 4,
  parameter int VALUE_W  = 14,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  frame_start,
  output logic                  ready,
  output logic [5*DIGITS-1:0]   glyphs,
  output logic                  done,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CMP_W = BCD_W + VALUE_W;
  localparam int CNT_W = $clog2(VALUE_W + 1);
  localparam logic [CMP_W-1:0] MAX_VAL = CMP_W'(10 ** DIGITS - 1);

  localparam logic [4:0] GLYPH_BLANK = 5'd16;
  localparam logic [4:0] GLYPH_DASH  = 5'd17;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_HOLD    = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [VALUE_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [5*DIGITS-1:0]  glyphs_q, glyphs_d;
  logic                 overflow_q, overflow_d;
  logic                 done_q, done_d;

  logic [BCD_W-1:0]     bcd_adj;
  logic [5*DIGITS-1:0]  glyph_fmt;
  logic                 lead_zero;

  // NOTE: every variable written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    glyphs_d   = glyphs_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;

    // Add-3 correction: any nibble >= 5 would carry past 9 after the doubling shift.
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    // Commit formatting: scan from the most significant digit down, blanking zeros
    // until the first nonzero digit. The units digit is always shown.
    lead_zero = (BLANK_LZ != 0);
    glyph_fmt = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (ovf_q) begin
        glyph_fmt[5*i +: 5] = GLYPH_DASH;
      end else if (lead_zero && (i != 0) && (bcd_q[4*i +: 4] == 4'd0)) begin
        glyph_fmt[5*i +: 5] = GLYPH_BLANK;
      end else begin
        glyph_fmt[5*i +: 5] = {1'b0, bcd_q[4*i +: 4]};
        lead_zero           = 1'b0;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          bin_d   = value;
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = (CMP_W'(value) > MAX_VAL);
          state_d = S_CONVERT;
        end
      end
      S_CONVERT: begin
        // {bcd,bin} shifted left as one long register.
        bcd_d = (bcd_adj << 1) | BCD_W'(bin_q[VALUE_W-1]);
        bin_d = bin_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(VALUE_W - 1)) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (frame_start) begin
          glyphs_d   = glyph_fmt;
          overflow_d = ovf_q;
          done_d     = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge value of every other flop.
  // NOTE: the datapath registers are reset along with the control state so that no
  // partial result from an interrupted conversion survives a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      glyphs_q   <= {DIGITS{GLYPH_BLANK}};
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      glyphs_q   <= glyphs_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign ready    = (state_q == S_IDLE);
  assign glyphs   = glyphs_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_value_glyph_encoder.sv
// Bench for value_glyph_encoder: two instances share every input, one blanking
// leading zeros and one showing them, and both are compared against a decimal
// reference model built from division and modulo.
module tb_value_glyph_encoder;

  localparam int DIGITS  = 4;
  localparam int VALUE_W = 14;
  localparam int LAT     = VALUE_W + 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                frame_start = 1'b0;
  logic [VALUE_W-1:0]  value = '0;

  logic                ready_a, done_a, ovf_a;
  logic [5*DIGITS-1:0] glyphs_a;
  logic                ready_b, done_b, ovf_b;
  logic [5*DIGITS-1:0] glyphs_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  value_glyph_encoder #(.DIGITS(DIGITS), .VALUE_W(VALUE_W), .BLANK_LZ(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .value(value), .frame_start(frame_start),
    .ready(ready_a), .glyphs(glyphs_a), .done(done_a), .overflow(ovf_a)
  );

  value_glyph_encoder #(.DIGITS(DIGITS), .VALUE_W(VALUE_W), .BLANK_LZ(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .value(value), .frame_start(frame_start),
    .ready(ready_b), .glyphs(glyphs_b), .done(done_b), .overflow(ovf_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Decimal readout expected for value v: out of range -> all dashes; otherwise
  // digit i is (v / 10^i) % 10, blanked when blanking is on and v < 10^i.
  function automatic logic [5*DIGITS-1:0] model(input int v, input bit blank);
    logic [5*DIGITS-1:0] g;
    int p;
    int lim;
    g   = '0;
    lim = 1;
    for (int i = 0; i < DIGITS; i++) lim = lim * 10;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v >= lim)                      g[5*i +: 5] = 5'd17;
      else if (blank && i > 0 && v < p)  g[5*i +: 5] = 5'd16;
      else                               g[5*i +: 5] = 5'((v / p) % 10);
      p = p * 10;
    end
    return g;
  endfunction

  function automatic bit model_ovf(input int v);
    return v > 9999;
  endfunction

  // Full transaction from a negedge: start pulse, frame_start pulse d cycles after
  // HOLD is entered (held from the start when d == 0), then check the commit.
  task automatic convert(input int v, input int d, input string tag);
    int c;
    bit got;
    value       = v[VALUE_W-1:0];
    start       = 1'b1;
    frame_start = (d == 0);
    got         = 1'b0;
    c           = 0;
    for (int k = 1; k <= LAT + d + 10; k++) begin
      @(negedge clk);
      if (done_a) begin
        got = 1'b1;
        c   = k;
        break;
      end
      start = 1'b0;
      if (k == LAT + d) frame_start = 1'b1;
    end
    frame_start = 1'b0;
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    if (got) begin
      // Cycles counted from the accepting edge E0 to the commit edge.
      check({tag, "_latency"}, 32'(c - 1), 32'(LAT + d));
      check({tag, "_glyphs_blank"}, 32'(glyphs_a), 32'(model(v, 1'b1)));
      check({tag, "_glyphs_zero"}, 32'(glyphs_b), 32'(model(v, 1'b0)));
      check({tag, "_overflow"}, 32'({ovf_a, ovf_b}), 32'({2{model_ovf(v)}}));
      check({tag, "_ready"}, 32'({ready_a, ready_b}), 32'd3);
      check({tag, "_done_b"}, 32'(done_b), 32'd1);
      @(negedge clk);
      check({tag, "_done_one_cycle"}, 32'({done_a, done_b}), 32'd0);
    end
  endtask

  initial begin
    logic [5*DIGITS-1:0] old_a;
    logic [5*DIGITS-1:0] old_b;
    int seen_done;
    int seen_busy;
    int v;

    // 1. reset state
    repeat (3) @(negedge clk);
    check("reset_glyphs_a", 32'(glyphs_a), 32'h0084210);
    check("reset_glyphs_b", 32'(glyphs_b), 32'h0084210);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", 32'({ready_a, ready_b}), 32'd3);
    check("reset_done", 32'({done_a, done_b}), 32'd0);
    check("reset_overflow", 32'({ovf_a, ovf_b}), 32'd0);
    check("idle_glyphs_a", 32'(glyphs_a), 32'(model(0, 1'b1) | 20'h0084200 | 20'h10));

    // 2. basic conversion with frame_start held high
    convert(1234, 0, "v1234");

    // 3. leading zeros, blanked and shown
    convert(7, 0, "v7");
    convert(0, 0, "v0");

    // 4. overflow boundary
    convert(10000, 0, "v10000");
    convert(9999, 0, "v9999");
    convert(16383, 0, "v16383");
    convert(1000, 0, "v1000");

    // 5. frame_start withheld for 100 cycles; start kept high the whole time,
    //    including the commit edge
    old_a       = glyphs_a;
    old_b       = glyphs_b;
    value       = 14'd42;
    start       = 1'b1;
    @(negedge clk);
    value       = 14'd9876;
    seen_done   = 0;
    seen_busy   = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done_a || done_b) seen_done++;
      if (ready_a || ready_b || glyphs_a !== old_a || glyphs_b !== old_b) seen_busy++;
    end
    check("hold_no_done", 32'(seen_done), 32'd0);
    check("hold_outputs_frozen", 32'(seen_busy), 32'd0);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("hold_done", 32'({done_a, done_b}), 32'd3);
    check("hold_glyphs_a", 32'(glyphs_a), 32'(model(42, 1'b1)));
    check("hold_glyphs_b", 32'(glyphs_b), 32'(model(42, 1'b0)));
    // A start coincident with the commit edge must not have been accepted.
    check("commit_start_ignored", 32'({ready_a, ready_b}), 32'd3);
    start = 1'b0;
    @(negedge clk);
    check("hold_done_one_cycle", 32'({done_a, done_b}), 32'd0);
    check("hold_ready_after", 32'({ready_a, ready_b}), 32'd3);

    // 6. reset in the middle of a conversion (after step 7 of 5555)
    value = 14'd5555;
    start = 1'b1;
    @(negedge clk);          // E0 accepted
    start = 1'b0;
    repeat (7) @(negedge clk); // E1..E7 done
    check("mid_busy", 32'({ready_a, ready_b}), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_glyphs_a", 32'(glyphs_a), 32'h0084210);
    check("mid_rst_glyphs_b", 32'(glyphs_b), 32'h0084210);
    check("mid_rst_ready", 32'({ready_a, ready_b}), 32'd3);
    check("mid_rst_done_ovf", 32'({done_a, done_b, ovf_a, ovf_b}), 32'd0);
    @(negedge clk);
    rst_n       = 1'b1;
    frame_start = 1'b1;
    seen_done   = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done_a || done_b) seen_done++;
    end
    frame_start = 1'b0;
    check("mid_rst_no_done", 32'(seen_done), 32'd0);
    convert(5555, 0, "v5555");

    // Randomized values and frame_start phases against the model.
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 3))
        0:       v = int'($urandom_range(0, 16383));
        1:       v = int'($urandom_range(0, 99));
        default: v = int'($urandom_range(0, 9999));
      endcase
      convert(v, int'($urandom_range(0, 4)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
